// File: rtl/baudgen_pkg.sv
// Shared constants and types for the programmable baud tick generator.
// Divisor values assume a 12 MHz system clock.
package baudgen_pkg;

  localparam int BAUDGEN_MIN_DIV = 2;

  localparam int B230400 = 52;
  localparam int B115200 = 104;
  localparam int B57600  = 208;
  localparam int B38400  = 313;
  localparam int B19200  = 625;
  localparam int B9600   = 1250;
  localparam int B4800   = 2500;

  typedef enum logic {
    MODE_TX = 1'b0,
    MODE_RX = 1'b1
  } baud_mode_e;

endpackage

// File: rtl/baudgen_frac_acc.sv
// Fractional phase accumulator: adds the fractional divisor at each tick and
// reports the carry that stretches the following period by one cycle.
module baudgen_frac_acc #(
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              step,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry
);

  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, frac};
    carry = step & sum[FRAC_W];
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (step) begin
      acc_d = sum[FRAC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/baudgen_prog.sv
// Runtime-programmable baud tick generator with tx and rx (mid-bit) phasing.
// Define BAUDGEN_FRAC_EN to add the fractional divisor input and accumulator.
module baudgen_prog
  import baudgen_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 104,
  parameter int FRAC_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             mode_rx,
  input  logic             div_wr,
  input  logic [DIV_W-1:0] div_in,
`ifdef BAUDGEN_FRAC_EN
  input  logic [FRAC_W-1:0] frac_in,
`endif
  output logic             tick,
  output logic             mid_tick,
  output logic             div_pend,
  output logic             div_err
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             err_q, err_d;
  baud_mode_e       mode_q, mode_d;

  logic             wr_ok;
  logic             wr_bad;
  logic             at_zero;
  logic [DIV_W-1:0] div_next;
  logic             period_carry;

  assign at_zero = (cnt_q == '0);
  assign wr_ok   = div_wr & (div_in >= DIV_W'(BAUDGEN_MIN_DIV));
  assign wr_bad  = div_wr & ~wr_ok;

  // A write landing on the tick cycle itself takes effect for that reload.
  assign div_next = wr_ok      ? div_in :
                    pend_vld_q ? pend_q : div_q;

`ifdef BAUDGEN_FRAC_EN
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [FRAC_W-1:0] pend_frac_q, pend_frac_d;
  logic [FRAC_W-1:0] frac_next;

  assign frac_next = wr_ok      ? frac_in :
                     pend_vld_q ? pend_frac_q : frac_q;

  baudgen_frac_acc #(
    .FRAC_W (FRAC_W)
  ) u_frac_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (~ena),
    .step  (tick),
    .frac  (frac_q),
    .carry (period_carry)
  );
`else
  // Integer-only build: every period is exactly the divisor.
  assign period_carry = (FRAC_W < 0);
`endif

  assign tick     = ena & at_zero & ~rst;
  assign mid_tick = ena & (mode_q == MODE_TX) & (cnt_q == (div_q >> 1)) & ~at_zero;
  assign div_pend = pend_vld_q;
  assign div_err  = err_q;

  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    mode_d     = mode_q;
    err_d      = wr_bad;
`ifdef BAUDGEN_FRAC_EN
    frac_d      = frac_q;
    pend_frac_d = pend_frac_q;
`endif

    if (wr_ok) begin
      pend_d     = div_in;
      pend_vld_d = 1'b1;
`ifdef BAUDGEN_FRAC_EN
      pend_frac_d = frac_in;
`endif
    end

    if (!ena) begin
      // Idle: re-arm the phase so the first tick lands at 0 (tx) or D/2 (rx).
      mode_d = baud_mode_e'(mode_rx);
      cnt_d  = mode_rx ? (div_q >> 1) : '0;
      if (pend_vld_q) begin
        div_d = pend_q;
`ifdef BAUDGEN_FRAC_EN
        frac_d = pend_frac_q;
`endif
        if (!wr_ok) begin
          pend_vld_d = 1'b0;
        end
      end
    end else if (at_zero) begin
      div_d      = div_next;
      pend_vld_d = 1'b0;
      cnt_d      = div_next - DIV_W'(1) + {{(DIV_W-1){1'b0}}, period_carry};
`ifdef BAUDGEN_FRAC_EN
      frac_d = frac_next;
`endif
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      div_q      <= DIV_W'(DEFAULT_DIV);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      err_q      <= 1'b0;
      mode_q     <= MODE_TX;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      err_q      <= err_d;
      mode_q     <= mode_d;
    end
  end

`ifdef BAUDGEN_FRAC_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frac_q      <= '0;
      pend_frac_q <= '0;
    end else begin
      frac_q      <= frac_d;
      pend_frac_q <= pend_frac_d;
    end
  end
`endif

endmodule

// File: tb/tb_baudgen_prog.sv
// Directed bench for baudgen_prog: tx/rx phasing, divisor writes, errors,
// reset mid-run and ena drop; fractional periods when BAUDGEN_FRAC_EN is set.
module tb_baudgen_prog;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        mode_rx;
  logic        div_wr;
  logic [15:0] div_in;
`ifdef BAUDGEN_FRAC_EN
  logic [3:0]  frac_in;
`endif
  logic        tick;
  logic        mid_tick;
  logic        div_pend;
  logic        div_err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  baudgen_prog #(
    .DIV_W       (16),
    .DEFAULT_DIV (104),
    .FRAC_W      (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .mode_rx  (mode_rx),
    .div_wr   (div_wr),
    .div_in   (div_in),
`ifdef BAUDGEN_FRAC_EN
    .frac_in  (frac_in),
`endif
    .tick     (tick),
    .mid_tick (mid_tick),
    .div_pend (div_pend),
    .div_err  (div_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // ena already high at cycle 0, tx phase, counter armed at zero.
  task automatic run_tx(input int n, input int d, input string tag);
    for (int k = 0; k < n; k++) begin
      sample();
      check({tag, "_tick"}, tick, (k % d) == 0);
      check({tag, "_mid"}, mid_tick, (k % d) == (d / 2));
      adv();
    end
  endtask

  task automatic write_div(input logic [15:0] v);
    div_wr = 1'b1;
    div_in = v;
    adv();
    div_wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; mode_rx = 1'b0; div_wr = 1'b0; div_in = '0;
`ifdef BAUDGEN_FRAC_EN
    frac_in = '0;
`endif
    adv();
    adv();
    rst = 1'b0;
    sample();
    check("rst_tick", tick, 0);
    check("rst_mid", mid_tick, 0);
    check("rst_pend", div_pend, 0);
    check("rst_err", div_err, 0);
    adv();

    for (int k = 0; k < 5; k++) begin
      sample();
      check("idle_tick", tick, 0);
      adv();
    end

    // Default divisor 104 in tx mode: ticks 0,104,208; mid 52,156.
    ena = 1'b1;
    run_tx(210, 104, "tx104");

    // Program D=10 while idle, then rx phase: ticks at 5,15,25, no mid_tick.
    ena = 1'b0;
    write_div(16'd10);
    sample();
    check("idle_wr_pend", div_pend, 1);
    adv();
    sample();
    check("idle_apply_pend", div_pend, 0);
    mode_rx = 1'b1;
    adv();
    ena = 1'b1;
    for (int k = 0; k < 30; k++) begin
      sample();
      check("rx10_tick", tick, (k >= 5) && ((k - 5) % 10 == 0));
      check("rx10_mid", mid_tick, 0);
      adv();
    end

    // tx, D=10, write 20 at cycle 3: ticks 0,10,30,50; mid 5,20,40.
    ena = 1'b0;
    mode_rx = 1'b0;
    adv();
    ena = 1'b1;
    for (int k = 0; k < 55; k++) begin
      div_wr = (k == 3);
      div_in = 16'd20;
      sample();
      check("wr20_tick", tick, (k == 0) || (k == 10) || (k == 30) || (k == 50));
      check("wr20_mid", mid_tick, (k == 5) || (k == 20) || (k == 40));
      check("wr20_pend", div_pend, (k >= 4) && (k <= 10));
      adv();
    end
    div_wr = 1'b0;

    // Rejected writes: div_err pulses, divisor stays 20.
    ena = 1'b0;
    adv();
    div_wr = 1'b1;
    div_in = 16'd1;
    sample();
    check("err1_same", div_err, 0);
    adv();
    div_wr = 1'b0;
    sample();
    check("err1_pulse", div_err, 1);
    check("err1_pend", div_pend, 0);
    adv();
    sample();
    check("err1_clear", div_err, 0);
    write_div(16'd0);
    sample();
    check("err0_pulse", div_err, 1);
    check("err0_pend", div_pend, 0);
    adv();
    ena = 1'b1;
    run_tx(45, 20, "keep20");

    // Reset while running with a write pending: back to 104, pending lost.
    write_div(16'd50);
    sample();
    check("prerst_pend", div_pend, 1);
    rst = 1'b1;
    sample();
    check("inrst_tick", tick, 0);
    adv();
    rst = 1'b0;
    ena = 1'b0;
    sample();
    check("postrst_pend", div_pend, 0);
    check("postrst_tick", tick, 0);
    adv();
    ena = 1'b1;
    run_tx(105, 104, "postrst");

    // D=10 tx, ena low on cycles 7-8: re-raise at 9 ticks at once.
    ena = 1'b0;
    write_div(16'd10);
    adv();
    for (int k = 0; k < 21; k++) begin
      ena = !((k == 7) || (k == 8));
      sample();
      check("drop_tick", tick, (k == 0) || (k == 9) || (k == 19));
      check("drop_mid", mid_tick, (k == 5) || (k == 14));
      adv();
    end

`ifdef BAUDGEN_FRAC_EN
    // D=10, frac=8/16: periods alternate 10,11; 32 periods span 336 cycles.
    begin
      int next_tick;
      int period;
      int n_ticks;
      ena = 1'b0;
      frac_in = 4'd8;
      write_div(16'd10);
      adv();
      ena = 1'b1;
      next_tick = 0;
      period = 10;
      n_ticks = 0;
      for (int k = 0; k <= 336; k++) begin
        sample();
        check("frac_tick", tick, k == next_tick);
        if (k == next_tick) begin
          next_tick = next_tick + period;
          period = (period == 10) ? 11 : 10;
        end
        if (tick && k < 336) n_ticks++;
        adv();
      end
      check("frac_count", n_ticks, 32);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
